// File: rtl/gnr_pkg.sv
// Shared constants for the gene-regulatory-network node: size limits and
// common truth tables for 3-input nodes.
package gnr_pkg;
    localparam int GNR_MAX_N_IN = 6;
    localparam int GNR_CNT_W    = 8;

    // Truth tables indexed by {in[2], in[1], in[0]}
    localparam logic [7:0] LUT_AND3 = 8'h80;
    localparam logic [7:0] LUT_OR3  = 8'hFE;
    localparam logic [7:0] LUT_MAJ3 = 8'hE8;
endpackage

// File: rtl/gnr_lut_eval.sv
// Combinational truth-table lookup: selects one bit of the table using the
// regulator-state vector as the index.
module gnr_lut_eval #(
    parameter int N_IN  = 3,
    parameter int LUT_W = 2**N_IN
) (
    input  logic [LUT_W-1:0] i_lut,
    input  logic [N_IN-1:0]  i_idx,
    output logic             o_bit
);
    assign o_bit = i_lut[i_idx];
endmodule

// File: rtl/gnr_node_lut.sv
// GRN node with a runtime-loadable truth table, slow/fast trajectory copies
// for attractor detection, a sticky meet flag and a saturating flip counter.
module gnr_node_lut
    import gnr_pkg::*;
#(
    parameter int               N_IN     = 3,
    parameter int               LUT_W    = 2**N_IN,
    parameter logic [LUT_W-1:0] LUT_INIT = LUT_AND3,
    parameter int               SLOW_DIV = 2,
    parameter int               CNT_W    = GNR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_nos,
    input  logic             init_state,
    input  logic             start_s0,
    input  logic             start_s1,
    input  logic [N_IN-1:0]  in_s0,
    input  logic [N_IN-1:0]  in_s1,
    input  logic             lut_we,
    input  logic [LUT_W-1:0] lut_data,
    output logic             s0,
    output logic             s1,
    output logic             out_s0,
    output logic             out_s1,
    output logic             meet,
    output logic [CNT_W-1:0] flips
);
    localparam int DW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(SLOW_DIV - 1);

    logic [LUT_W-1:0] r_lut;
    logic [DW-1:0]    r_dcnt;
    logic             r_s0;
    logic             r_s1;
    logic             r_meet;
    logic [CNT_W-1:0] r_flips;

    logic w_s0_nxt;
    logic w_s1_nxt;
    logic w_s0_upd;

    // Both lookups read the registered table, so a same-cycle load only
    // affects evaluations from the following cycle onward.
    gnr_lut_eval #(.N_IN(N_IN), .LUT_W(LUT_W)) u_eval_s0 (
        .i_lut (r_lut),
        .i_idx (in_s0),
        .o_bit (w_s0_nxt)
    );

    gnr_lut_eval #(.N_IN(N_IN), .LUT_W(LUT_W)) u_eval_s1 (
        .i_lut (r_lut),
        .i_idx (in_s1),
        .o_bit (w_s1_nxt)
    );

    assign w_s0_upd = start_s0 && (r_dcnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lut   <= LUT_INIT;
            r_dcnt  <= DCNT_LAST;
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_meet  <= 1'b0;
            r_flips <= '0;
        end else begin
            if (lut_we) begin
                r_lut <= lut_data;
            end
            if (reset_nos) begin
                r_dcnt  <= '0;
                r_s0    <= init_state;
                r_s1    <= init_state;
                r_meet  <= 1'b0;
                r_flips <= '0;
            end else begin
                if (start_s0) begin
                    if (r_dcnt == '0) begin
                        r_s0 <= w_s0_nxt;
                    end
                    r_dcnt <= (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + 1'b1;
                end
                if (start_s1) begin
                    r_s1 <= w_s1_nxt;
                    if ((w_s1_nxt != r_s1) && (r_flips != '1)) begin
                        r_flips <= r_flips + 1'b1;
                    end
                end
                // Meet only counts when both copies step together
                if (w_s0_upd && start_s1 && (w_s0_nxt == w_s1_nxt)) begin
                    r_meet <= 1'b1;
                end
            end
        end
    end

    assign s0     = r_s0;
    assign s1     = r_s1;
    assign out_s0 = r_s0;
    assign out_s1 = r_s1;
    assign meet   = r_meet;
    assign flips  = r_flips;
endmodule

// File: tb/tb_gnr_node_lut.sv
// Directed scoreboard bench for gnr_node_lut (N_IN=3, SLOW_DIV=2, CNT_W=2).
module tb_gnr_node_lut;
    localparam int N_IN  = 3;
    localparam int LUT_W = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             reset_nos;
    logic             init_state;
    logic             start_s0;
    logic             start_s1;
    logic [N_IN-1:0]  in_s0;
    logic [N_IN-1:0]  in_s1;
    logic             lut_we;
    logic [LUT_W-1:0] lut_data;
    logic             s0;
    logic             s1;
    logic             out_s0;
    logic             out_s1;
    logic             meet;
    logic [CNT_W-1:0] flips;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    gnr_node_lut #(
        .N_IN     (N_IN),
        .LUT_INIT (8'h80),
        .SLOW_DIV (2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start_s0   (start_s0),
        .start_s1   (start_s1),
        .in_s0      (in_s0),
        .in_s1      (in_s1),
        .lut_we     (lut_we),
        .lut_data   (lut_data),
        .s0         (s0),
        .s1         (s1),
        .out_s0     (out_s0),
        .out_s1     (out_s1),
        .meet       (meet),
        .flips      (flips)
    );

    always #5 clk = ~clk;

    // sel: 0=s0 1=s1 2=meet 3=flips 4=out_s0 5=out_s1
    task automatic expect_v(input string tag, input int sel, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t       e;
        logic [7:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                0:       obs = {7'd0, s0};
                1:       obs = {7'd0, s1};
                2:       obs = {7'd0, meet};
                3:       obs = {6'd0, flips};
                4:       obs = {7'd0, out_s0};
                default: obs = {7'd0, out_s1};
            endcase
            n_cmp++;
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock: outputs sampled 1 time unit after the edge, then pulses cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
        rst       = 1'b0;
        reset_nos = 1'b0;
        start_s0  = 1'b0;
        start_s1  = 1'b0;
        lut_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; reset_nos = 1'b0; init_state = 1'b0;
        start_s0 = 1'b0; start_s1 = 1'b0;
        in_s0 = '0; in_s1 = '0; lut_we = 1'b0; lut_data = '0;

        // Reset state
        expect_v("rst_s0", 0, 0); expect_v("rst_s1", 1, 0);
        expect_v("rst_meet", 2, 0); expect_v("rst_flips", 3, 0);
        tick();

        // Default AND table
        reset_nos = 1; init_state = 1;
        expect_v("nos_s0", 0, 1); expect_v("nos_s1", 1, 1);
        expect_v("nos_out_s0", 4, 1); expect_v("nos_out_s1", 5, 1);
        tick();
        start_s1 = 1; in_s1 = 3'b111;
        expect_v("and_111_s1", 1, 1); expect_v("and_111_flips", 3, 0);
        tick();
        start_s1 = 1; in_s1 = 3'b011;
        expect_v("and_011_s1", 1, 0); expect_v("and_011_flips", 3, 1);
        expect_v("and_011_out_s1", 5, 0);
        tick();

        // Divider, all-ones input
        reset_nos = 1; init_state = 0;
        expect_v("div_nos_s0", 0, 0); expect_v("div_nos_flips", 3, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            start_s0 = 1; in_s0 = 3'b111;
            expect_v($sformatf("div_a_p%0d", i + 1), 0, 1);
            tick();
            tick();
        end

        // Divider: value change only lands on the 3rd pulse
        reset_nos = 1; init_state = 0;
        tick();
        start_s0 = 1; in_s0 = 3'b111; expect_v("div_b_p1", 0, 1); tick();
        start_s0 = 1; in_s0 = 3'b000; expect_v("div_b_p2", 0, 1); tick();
        start_s0 = 1; in_s0 = 3'b000; expect_v("div_b_p3", 0, 0); tick();
        start_s0 = 1; in_s0 = 3'b111; expect_v("div_b_p4", 0, 0); tick();

        // Divider phase after rst: first pulse skipped
        rst = 1; expect_v("prst_s0", 0, 0); tick();
        start_s0 = 1; in_s0 = 3'b111; expect_v("prst_p1", 0, 0); tick();
        start_s0 = 1; in_s0 = 3'b111; expect_v("prst_p2", 0, 1); tick();

        // LUT load colliding with evaluation
        lut_we = 1; lut_data = 8'hFE; start_s1 = 1; in_s1 = 3'b001;
        expect_v("coll_old_s1", 1, 0); expect_v("coll_old_flips", 3, 0);
        tick();
        start_s1 = 1; in_s1 = 3'b001;
        expect_v("coll_new_s1", 1, 1); expect_v("coll_new_flips", 3, 1);
        tick();

        // Meet: equality without a joint step must not set it
        reset_nos = 1; init_state = 0; tick();
        start_s1 = 1; in_s1 = 3'b111; expect_v("meet_s1only", 1, 1); tick();
        start_s0 = 1; in_s0 = 3'b111;
        expect_v("meet_s0only_s0", 0, 1); expect_v("meet_eq_nojoint", 2, 0);
        tick();
        start_s0 = 1; start_s1 = 1; in_s0 = 3'b111; in_s1 = 3'b111;
        expect_v("meet_dcnt1_joint", 2, 0);
        tick();
        start_s0 = 1; start_s1 = 1; in_s0 = 3'b111; in_s1 = 3'b111;
        expect_v("meet_joint", 2, 1);
        tick();
        start_s1 = 1; in_s1 = 3'b000;
        expect_v("meet_sticky_s1", 1, 0); expect_v("meet_sticky", 2, 1);
        tick();
        start_s0 = 1; start_s1 = 1; in_s0 = 3'b111; in_s1 = 3'b000;
        expect_v("meet_sticky2", 2, 1);
        tick();

        // reset_nos clears meet and still honours lut_we (back to AND)
        reset_nos = 1; init_state = 0; lut_we = 1; lut_data = 8'h80;
        expect_v("meet_clear", 2, 0);
        tick();
        start_s1 = 1; in_s1 = 3'b011; expect_v("nos_lutwe_s1", 1, 0); tick();

        // Flip counter saturation at 3
        reset_nos = 1; init_state = 0; tick();
        for (int i = 0; i < 5; i++) begin
            start_s1 = 1;
            in_s1 = (i % 2 == 0) ? 3'b111 : 3'b000;
            expect_v($sformatf("sat_s1_%0d", i), 1, (i % 2 == 0) ? 8'd1 : 8'd0);
            expect_v($sformatf("sat_flips_%0d", i), 3, (i < 3) ? 8'(i + 1) : 8'd3);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/gnr_node_lut.md
Name: gnr_node_lut

Overview:
- Parametrised successor to the fixed-function gene-regulatory-network node.
- Node next-state is a runtime-loadable truth table over N_IN regulator inputs, not a hard-wired Boolean expression.
- Keeps the two trajectory copies used for cycle/attractor detection:
  - slow copy s0 updates once every SLOW_DIV start_s0 pulses;
  - fast copy s1 updates on every start_s1 pulse.
- Adds a sticky meet flag (s0/s1 coincide) and a saturating s1 flip counter. Instantiated once per network node inside the GRN simulator core.

Parameters:
- N_IN, 3, number of regulator inputs (1..6).
- LUT_W, 2**N_IN, truth-table width (derived; do not override).
- LUT_INIT, 8'h80, truth table after rst (default = 3-input AND).
- SLOW_DIV, 2, slow-copy update divider (>=1; 1 = s0 updates on every start_s0).
- CNT_W, 8, flip-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- reset_nos  in  1  reload both copies with init_state and restart divider/counters.
- init_state  in  1  value loaded into s0/s1 on reset_nos.
- start_s0  in  1  slow-copy step request.
- start_s1  in  1  fast-copy step request.
- in_s0  in  N_IN  regulator states for slow copy; bit 0 is LUT index LSB.
- in_s1  in  N_IN  regulator states for fast copy.
- lut_we  in  1  load truth table.
- lut_data  in  LUT_W  new truth table.
- s0  out  1  slow-copy state (registered).
- s1  out  1  fast-copy state (registered).
- out_s0  out  1  equals s0; fan-out to downstream nodes.
- out_s1  out  1  equals s1; fan-out to downstream nodes.
- meet  out  1  sticky: copies coincided on a joint update.
- flips  out  CNT_W  number of s1 value changes since reset_nos, saturating.

Behaviour:
- rst (highest priority):
  - s0=0, s1=0, lut=LUT_INIT, meet=0, flips=0;
  - divider dcnt=SLOW_DIV-1, so the first start_s0 after rst does NOT update s0 when SLOW_DIV>1.
- reset_nos (when not rst): s0=s1=init_state, dcnt=0, meet=0, flips=0; start_s0/start_s1 ignored that cycle.
- Independence from reset_nos: lut_we is still honoured during reset_nos. lut_we loads lut<=lut_data.
- Slow copy, on start_s0 (not rst/reset_nos):
  - update s0 <= lut[in_s0] iff dcnt==0;
  - then dcnt <= (dcnt==SLOW_DIV-1) ? 0 : dcnt+1.
  - SLOW_DIV=2 gives updates on the 1st, 3rd, 5th... start_s0 after reset_nos.
- Fast copy, on start_s1 (not rst/reset_nos): s1 <= lut[in_s1].
- Latency and timing:
  - one cycle from start to new s0/s1; lut read is combinational from the current-cycle inputs.
  - lut_we and a start in the same cycle: evaluation uses the OLD table; the new table is visible next cycle.
- Flip counter:
  - flips increments when s1 updates to a value different from the current s1;
  - saturates at 2**CNT_W-1, no wrap.
- Meet flag:
  - set when, in one cycle, s0 updates (dcnt==0 and start_s0) AND s1 updates AND both new values are equal;
  - stays set until rst/reset_nos;
  - equal values without a joint update do not set it.
- start_s0 and start_s1 are fully independent and may coincide.
- out_s0/out_s1 are wires from s0/s1.

Decomposition:
- Package gnr_pkg: max N_IN constant (6), default LUT_INIT constants (AND3=8'h80, OR3=8'hFE, MAJ3=8'hE8), CNT_W default.
- One sub-module, gnr_lut_eval: combinational LUT_W-to-1 mux indexed by an N_IN-bit vector, instantiated twice (s0 and s1 paths). Divider, counter and meet logic stay in the top module.

Test Plan:
- Reset / LUT default: rst, then reset_nos with init_state=1, then in_s1=3'b111 with start_s1 -> s1=1; then in_s1=3'b011 with start_s1 -> s1=0, flips=1.
- Divider, SLOW_DIV=2:
  - reset_nos, then 4 start_s0 pulses with in_s0=3'b111 and init_state=0 -> s0 becomes 1 after the 1st pulse, holds through the 2nd;
  - repeat with in_s0=0 -> changes only on the 3rd pulse.
- Post-rst divider phase: rst, then start_s0 with in_s0=3'b111 -> s0 stays 0; the 2nd pulse -> s0=1.
- LUT load collision:
  - lut_we with lut_data=8'hFE in the same cycle as start_s1, in_s1=3'b001 -> s1 uses AND (0);
  - next start_s1 -> s1=1.
- Meet sticky:
  - joint start_s0 (dcnt==0) and start_s1, both inputs 3'b111 -> meet=1 next cycle;
  - meet stays 1 through later mismatched updates; reset_nos clears it.
- Saturation, CNT_W=2: toggle s1 five times -> flips goes 1, 2, 3, 3, 3.
